// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: opcode low bits, flag bit
// positions and the shift sequencer state type.
package ex_pkg;

    // Integer class, opcode[1:0]
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    // Logic class, opcode[1:0]
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Shift class, opcode[1:0]
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    // Flag register bit positions; bit 0 is always zero
    localparam int FLAG_Z = 5;
    localparam int FLAG_P = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;

    typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/ex_out_fifo.sv
// Small result queue with show-ahead head output. Head reads as zero while
// empty so the stage output is clean out of reset.
module ex_out_fifo #(
    parameter int WIDTH     = 32,
    parameter int OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(OUT_DEPTH);

    logic [WIDTH-1:0] r_mem [OUT_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(OUT_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap freely
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// Execute stage: add/sub, logic, shift, address and branch pass-through with
// a registered flag register and a small output queue. Shifts are either a
// one-cycle barrel shift or a one-bit-per-cycle serial sequencer.
module ex_pipe
    import ex_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int OUT_DEPTH    = 2,
    parameter int SERIAL_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_i,
    output logic             stall_o,
    input  logic [WIDTH-1:0] rd_value_i,
    input  logic [WIDTH-1:0] rs_value_i,
    input  logic [WIDTH-1:0] imm_value_i,
    input  logic [7:0]       opcode_i,
    input  logic             ctrl_inte_i,
    input  logic             ctrl_logic_i,
    input  logic             ctrl_shift_i,
    input  logic             ctrl_ld_i,
    input  logic             ctrl_st_i,
    input  logic             ctrl_br_i,
    input  logic             immf_i,
    output logic             v_o,
    input  logic             stall_i,
    output logic [WIDTH-1:0] result_o,
    output logic [5:0]       flags_o
);

    localparam int SHW = $clog2(WIDTH);

    // Operands and arithmetic
    logic [WIDTH-1:0] w_opr0;
    logic [WIDTH-1:0] w_opr1;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_addr;
    logic             w_sub;
    logic             w_ovf;
    logic [SHW-1:0]   w_amt;
    logic [SHW:0]     w_rol_rsh;
    logic [WIDTH-1:0] w_logic_res;
    logic [WIDTH-1:0] w_shift_res;

    // Single-cycle result selection
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_flag_upd;

    // Control and queue interface
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_ser_start;
    logic             w_done;
    logic             w_push;
    logic [WIDTH-1:0] w_push_data;
    logic             w_flag_we;
    logic [5:0]       w_flags_new;
    logic             w_unused_ok;

    // Serial shift sequencer state
    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_sop;
    logic [WIDTH-1:0] w_step;
    logic [5:0]       r_flags;

    assign w_unused_ok = ^opcode_i[7:2];

    assign w_opr0    = rd_value_i;
    assign w_opr1    = immf_i ? imm_value_i : rs_value_i;
    assign w_sub     = (opcode_i[1:0] == OP_SUB);
    assign w_addend  = w_sub ? ~w_opr1 : w_opr1;
    assign w_sum     = {1'b0, w_opr0} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf     = (w_opr0[WIDTH-1] == w_addend[WIDTH-1]) &
                       (w_sum[WIDTH-1] != w_opr0[WIDTH-1]);
    assign w_addr    = w_opr0 + w_opr1;
    assign w_amt     = w_opr1[SHW-1:0];
    assign w_rol_rsh = (SHW+1)'(WIDTH) - {1'b0, w_amt};

    // Bitwise logic unit
    always_comb begin
        w_logic_res = '0;
        case (opcode_i[1:0])
            OP_AND:  w_logic_res = w_opr0 & w_opr1;
            OP_OR:   w_logic_res = w_opr0 | w_opr1;
            OP_XOR:  w_logic_res = w_opr0 ^ w_opr1;
            default: w_logic_res = ~w_opr1;
        endcase
    end

    // Barrel shifter; a rotate by zero shifts the wrap part out by WIDTH, giving 0
    always_comb begin
        w_shift_res = '0;
        case (opcode_i[1:0])
            OP_SLL:  w_shift_res = w_opr0 << w_amt;
            OP_SRL:  w_shift_res = w_opr0 >> w_amt;
            OP_SRA:  w_shift_res = $signed(w_opr0) >>> w_amt;
            default: w_shift_res = (w_opr0 << w_amt) | (w_opr0 >> w_rol_rsh);
        endcase
    end

    // Op-class result mux with carry/overflow and flag-update qualifier
    always_comb begin
        w_res      = '0;
        w_c        = 1'b0;
        w_v        = 1'b0;
        w_flag_upd = 1'b0;
        if (ctrl_inte_i) begin
            w_res      = w_sum[WIDTH-1:0];
            w_c        = w_sum[WIDTH];
            w_v        = w_ovf;
            w_flag_upd = 1'b1;
        end else if (ctrl_logic_i) begin
            w_res      = w_logic_res;
            w_flag_upd = 1'b1;
        end else if (ctrl_shift_i) begin
            w_res      = w_shift_res;
            w_flag_upd = 1'b1;
        end else if (ctrl_ld_i | ctrl_st_i) begin
            w_res      = w_addr;
        end else if (ctrl_br_i) begin
            w_res      = w_opr1;
        end
    end

    // One-bit step of the serial shifter
    always_comb begin
        w_step = r_sh;
        case (r_sop)
            OP_SLL:  w_step = {r_sh[WIDTH-2:0], 1'b0};
            OP_SRL:  w_step = {1'b0, r_sh[WIDTH-1:1]};
            OP_SRA:  w_step = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
            default: w_step = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};
        endcase
    end

    // The queue is never full while shifting: accept required room and only
    // pops can happen until the shift completes.
    assign stall_o     = (r_state == SHIFT) | w_full;
    assign w_accept    = v_i & ~stall_o;
    assign w_ser_start = w_accept & ctrl_shift_i & (SERIAL_SHIFT != 0) & (w_amt != '0);
    assign w_done      = (r_state == SHIFT) & (r_cnt == SHW'(1));
    assign w_push      = (w_accept & ~w_ser_start) | w_done;
    assign w_push_data = w_done ? w_step : w_res;
    assign w_flag_we   = (w_accept & ~w_ser_start & w_flag_upd) | w_done;

    // Flags for the value being enqueued; serial shifts never set C or V
    always_comb begin
        w_flags_new         = '0;
        w_flags_new[FLAG_Z] = (w_push_data == '0);
        w_flags_new[FLAG_N] = w_push_data[WIDTH-1];
        w_flags_new[FLAG_P] = (w_push_data != '0) & ~w_push_data[WIDTH-1];
        w_flags_new[FLAG_C] = w_c & ~w_done;
        w_flags_new[FLAG_V] = w_v & ~w_done;
    end

    // Serial shift sequencer: load on accept, one bit per cycle, enqueue at count 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_sop   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ser_start) begin
                        r_sh    <= w_opr0;
                        r_cnt   <= w_amt;
                        r_sop   <= opcode_i[1:0];
                        r_state <= SHIFT;
                    end
                end
                default: begin
                    r_sh  <= w_step;
                    r_cnt <= r_cnt - SHW'(1);
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Flag register follows queue writes, not drains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= '0;
        end else if (w_flag_we) begin
            r_flags <= w_flags_new;
        end
    end

    assign flags_o = r_flags;
    assign v_o     = ~w_empty;

    ex_out_fifo #(
        .WIDTH     (WIDTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (~stall_i),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (result_o)
    );

endmodule

// File: tb/tb_ex_pipe.sv
// Directed bench for ex_pipe: a serial-shift instance and a barrel-shift
// instance share operand inputs, with separate handshakes.
module tb_ex_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_s = 1'b0, v_b = 1'b0;
    logic        stall_in_s = 1'b0, stall_in_b = 1'b0;
    logic [31:0] rd = '0, rs = '0, imm = '0;
    logic [7:0]  opcode = '0;
    logic        c_inte = 1'b0, c_logic = 1'b0, c_shift = 1'b0;
    logic        c_ld = 1'b0, c_st = 1'b0, c_br = 1'b0;
    logic        immf = 1'b0;

    logic        stall_s, stall_b, vo_s, vo_b;
    logic [31:0] res_s, res_b;
    logic [5:0]  flg_s, flg_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_pipe #(.WIDTH(32), .OUT_DEPTH(2), .SERIAL_SHIFT(1)) u_ser (
        .clk(clk), .rst(rst), .v_i(v_s), .stall_o(stall_s),
        .rd_value_i(rd), .rs_value_i(rs), .imm_value_i(imm), .opcode_i(opcode),
        .ctrl_inte_i(c_inte), .ctrl_logic_i(c_logic), .ctrl_shift_i(c_shift),
        .ctrl_ld_i(c_ld), .ctrl_st_i(c_st), .ctrl_br_i(c_br), .immf_i(immf),
        .v_o(vo_s), .stall_i(stall_in_s), .result_o(res_s), .flags_o(flg_s)
    );

    ex_pipe #(.WIDTH(32), .OUT_DEPTH(2), .SERIAL_SHIFT(0)) u_bar (
        .clk(clk), .rst(rst), .v_i(v_b), .stall_o(stall_b),
        .rd_value_i(rd), .rs_value_i(rs), .imm_value_i(imm), .opcode_i(opcode),
        .ctrl_inte_i(c_inte), .ctrl_logic_i(c_logic), .ctrl_shift_i(c_shift),
        .ctrl_ld_i(c_ld), .ctrl_st_i(c_st), .ctrl_br_i(c_br), .immf_i(immf),
        .v_o(vo_b), .stall_i(stall_in_b), .result_o(res_b), .flags_o(flg_b)
    );

    // At most one op class may be selected while valid
    always @(posedge clk) begin
        if (rst && (v_s || v_b)) begin
            assert ($onehot0({c_inte, c_logic, c_shift, c_ld, c_st, c_br}))
                else $error("illegal ctrl combination");
        end
    end

    typedef struct {
        logic [5:0]  ctrl;   // {inte, logic, shift, ld, st, br}
        logic [7:0]  op;
        logic        imf;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [31:0] exp_res;
        logic [5:0]  exp_flg;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [5:0] ctrl, input logic [7:0] op, input logic imf,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        {c_inte, c_logic, c_shift, c_ld, c_st, c_br} = ctrl;
        opcode = op;
        immf   = imf;
        rd     = a;
        rs     = b;
        imm    = im;
    endtask

    // Shift on both instances: barrel result at N+1, serial stalls N+1..N+k
    task automatic run_shift(input logic [7:0] op, input logic [31:0] a, input int k,
                             input logic [31:0] exp, input logic [5:0] ef);
        @(negedge clk);
        drive(6'b001000, op, 1'b0, a, 32'(k), 32'h0);
        v_s = 1'b1;
        v_b = 1'b1;
        @(negedge clk);
        v_s = 1'b0;
        v_b = 1'b0;
        chk($sformatf("bar sh%0d k%0d vo", op, k), 32'(vo_b), 32'd1);
        chk($sformatf("bar sh%0d k%0d res", op, k), res_b, exp);
        chk($sformatf("bar sh%0d k%0d flg", op, k), 32'(flg_b), 32'(ef));
        for (int c = 1; c <= k; c++) begin
            if (c > 1) @(negedge clk);
            chk($sformatf("ser sh%0d busy%0d stall", op, c), 32'(stall_s), 32'd1);
            chk($sformatf("ser sh%0d busy%0d vo", op, c), 32'(vo_s), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("ser sh%0d k%0d vo", op, k), 32'(vo_s), 32'd1);
        chk($sformatf("ser sh%0d k%0d res", op, k), res_s, exp);
        chk($sformatf("ser sh%0d k%0d flg", op, k), 32'(flg_s), 32'(ef));
        chk($sformatf("ser sh%0d k%0d stall", op, k), 32'(stall_s), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{6'b100000, 8'h00, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000, 6'b001010};
        vecs[1]  = '{6'b000100, 8'h00, 1'b1, 32'h00000010, 32'h12345678, 32'hFFFFFFF0, 32'h00000000, 6'b001010};
        vecs[2]  = '{6'b100000, 8'h01, 1'b0, 32'h00000005, 32'h00000005, 32'h0,        32'h00000000, 6'b100100};
        vecs[3]  = '{6'b100000, 8'h01, 1'b0, 32'h00000003, 32'h00000005, 32'h0,        32'hFFFFFFFE, 6'b001000};
        vecs[4]  = '{6'b100000, 8'h00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 6'b100100};
        vecs[5]  = '{6'b100000, 8'h01, 1'b0, 32'h80000000, 32'h00000001, 32'h0,        32'h7FFFFFFF, 6'b010110};
        vecs[6]  = '{6'b010000, 8'h00, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h00F000F0, 6'b010000};
        vecs[7]  = '{6'b010000, 8'h01, 1'b1, 32'h000000F0, 32'hDEADBEEF, 32'h0000000F, 32'h000000FF, 6'b010000};
        vecs[8]  = '{6'b010000, 8'h02, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h00000000, 6'b100000};
        vecs[9]  = '{6'b010000, 8'h03, 1'b0, 32'h12345678, 32'h00000000, 32'h0,        32'hFFFFFFFF, 6'b001000};
        vecs[10] = '{6'b000001, 8'h00, 1'b0, 32'h00000099, 32'h00001234, 32'h0,        32'h00001234, 6'b001000};
        vecs[11] = '{6'b000010, 8'h00, 1'b0, 32'h00000100, 32'h00000004, 32'h0,        32'h00000104, 6'b001000};
        vecs[12] = '{6'b000000, 8'h00, 1'b0, 32'h00000005, 32'h00000007, 32'h0,        32'h00000000, 6'b001000};
        vecs[13] = '{6'b001000, 8'h00, 1'b0, 32'h00000001, 32'h00000020, 32'h0,        32'h00000001, 6'b010000};
        vecs[14] = '{6'b000001, 8'h00, 1'b1, 32'h00000000, 32'h00000000, 32'h80000000, 32'h80000000, 6'b010000};

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("reset vo_s", 32'(vo_s), 32'd0);
        chk("reset res_s", res_s, 32'h0);
        chk("reset flg_s", 32'(flg_s), 32'h0);
        chk("reset stall_s", 32'(stall_s), 32'd0);
        chk("reset vo_b", 32'(vo_b), 32'd0);
        chk("reset flg_b", 32'(flg_b), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single-cycle table on both instances
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].ctrl, vecs[i].op, vecs[i].imf, vecs[i].a, vecs[i].b, vecs[i].im);
            chk($sformatf("vec%0d pre stall_s", i), 32'(stall_s), 32'd0);
            v_s = 1'b1;
            v_b = 1'b1;
            @(negedge clk);
            v_s = 1'b0;
            v_b = 1'b0;
            chk($sformatf("vec%0d vo_s", i), 32'(vo_s), 32'd1);
            chk($sformatf("vec%0d res_s", i), res_s, vecs[i].exp_res);
            chk($sformatf("vec%0d flg_s", i), 32'(flg_s), 32'(vecs[i].exp_flg));
            chk($sformatf("vec%0d res_b", i), res_b, vecs[i].exp_res);
            chk($sformatf("vec%0d flg_b", i), 32'(flg_b), 32'(vecs[i].exp_flg));
        end

        // Shifts: serial latency k+1, barrel latency 1
        run_shift(8'h02, 32'h80000000, 4,  32'hF8000000, 6'b001000);
        run_shift(8'h03, 32'h80000001, 1,  32'h00000003, 6'b010000);
        run_shift(8'h01, 32'h80000000, 31, 32'h00000001, 6'b010000);
        run_shift(8'h00, 32'h00000003, 3,  32'h00000018, 6'b010000);

        // Back-pressure on the serial instance
        @(negedge clk);
        stall_in_s = 1'b1;
        drive(6'b100000, 8'h00, 1'b0, 32'h0, 32'h1, 32'h0);
        v_s = 1'b1;
        @(negedge clk);
        chk("bp one entry stall", 32'(stall_s), 32'd0);
        rs = 32'h2;
        @(negedge clk);
        chk("bp full stall", 32'(stall_s), 32'd1);
        chk("bp full vo", 32'(vo_s), 32'd1);
        chk("bp full head", res_s, 32'h1);
        rs = 32'h3;
        repeat (2) begin
            @(negedge clk);
            chk("bp hold stall", 32'(stall_s), 32'd1);
            chk("bp hold head", res_s, 32'h1);
        end
        stall_in_s = 1'b0;
        @(negedge clk);
        chk("bp pop1 head", res_s, 32'h2);
        chk("bp pop1 stall", 32'(stall_s), 32'd0);
        chk("bp pop1 vo", 32'(vo_s), 32'd1);
        @(negedge clk);
        v_s = 1'b0;
        chk("bp pop2 head", res_s, 32'h3);
        chk("bp pop2 vo", 32'(vo_s), 32'd1);
        chk("bp flags", 32'(flg_s), 32'(6'b010000));
        @(negedge clk);
        chk("bp drained vo", 32'(vo_s), 32'd0);

        // Reset in the middle of a serial SRA
        @(negedge clk);
        drive(6'b001000, 8'h02, 1'b0, 32'h80000000, 32'h4, 32'h0);
        v_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_s = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst vo_s", 32'(vo_s), 32'd0);
        chk("midrst flg_s", 32'(flg_s), 32'h0);
        chk("midrst stall_s", 32'(stall_s), 32'd0);
        chk("midrst flg_b", 32'(flg_b), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("postrst stall_s", 32'(stall_s), 32'd0);
        chk("postrst vo_s", 32'(vo_s), 32'd0);
        @(negedge clk);
        drive(6'b100000, 8'h00, 1'b0, 32'h2, 32'h3, 32'h0);
        v_s = 1'b1;
        v_b = 1'b1;
        @(negedge clk);
        v_s = 1'b0;
        v_b = 1'b0;
        chk("postrst add vo_s", 32'(vo_s), 32'd1);
        chk("postrst add res_s", res_s, 32'h5);
        chk("postrst add flg_s", 32'(flg_s), 32'(6'b010000));
        chk("postrst add res_b", res_b, 32'h5);
        repeat (6) @(negedge clk);
        chk("postrst no stale shift", 32'(vo_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_pipe.md
Name: ex_pipe

Overview:
Parametrised execute stage that replaces the single-adder ex path. It covers integer add/sub, logic, shift and address/branch pass-through, and keeps a registered flag register. Results go through an OUT_DEPTH-entry output queue with a valid/stall handshake on both sides. Shifts run either as a one-cycle barrel shift or as a multi-cycle serial shift, selected at elaboration.

Parameters:
WIDTH, 32, datapath width in bits (power of 2, >=8)
OUT_DEPTH, 2, output queue entries (power of 2, >=2)
SERIAL_SHIFT, 0, 0 = single-cycle barrel shifter; 1 = serial shifter, one bit per cycle

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
v_i  input  1  upstream valid
stall_o  output  1  upstream stall; the stage accepts an op only when v_i=1 and stall_o=0
rd_value_i  input  WIDTH  operand 0
rs_value_i  input  WIDTH  operand 1 when immf_i=0
imm_value_i  input  WIDTH  operand 1 when immf_i=1
opcode_i  input  8  op detail, low 2 bits used
ctrl_inte_i, ctrl_logic_i, ctrl_shift_i, ctrl_ld_i, ctrl_st_i, ctrl_br_i  input  1 each  one-hot op class
immf_i  input  1  immediate select
v_o  output  1  result valid (queue non-empty)
stall_i  input  1  downstream stall; an entry pops when v_o=1 and stall_i=0
result_o  output  WIDTH  head-of-queue result
flags_o  output  6  {Z,P,N,C,V,0}, registered

Behaviour:
- Operands: opr0 = rd_value_i; opr1 = immf_i ? imm_value_i : rs_value_i. Inputs are sampled only on accept.
- inte: opcode[0]=0 computes opr0+opr1; opcode[0]=1 computes opr0-opr1, implemented as opr0+~opr1+1. C = carry-out (for sub, C=1 means no borrow). V = signed overflow.
- logic: opcode[1:0] 00 AND, 01 OR, 10 XOR, 11 NOT opr1. C=V=0.
- shift: amount = opr1[log2(WIDTH)-1:0]. opcode[1:0] 00 SLL, 01 SRL, 10 SRA, 11 ROL. C=V=0.
- ld/st: result = opr0+opr1 (address); flags unchanged. br: result = opr1; flags unchanged.
- No ctrl bit set with v_i=1: NOP, enqueues result 0, flags unchanged. More than one ctrl bit set is illegal (assertion in the bench).
- Z = result==0. N = result MSB. P = !Z & !N. Bit 0 is always 0.
- flags_o updates on the same edge the result is written into the queue, not when it drains.
- Latency, non-serial op accepted in cycle N: queue write at the end of N, v_o=1 from N+1.
- Serial shift with amount k>=1 (SERIAL_SHIFT=1):
  - FSM IDLE->SHIFT on accept; loads the shift register and count=k.
  - Each SHIFT cycle shifts one bit and decrements count.
  - The count==1 cycle writes the queue and returns to IDLE.
  - stall_o=1 during cycles N+1..N+k; v_o=1 from N+k+1.
  - k=0 behaves as a single-cycle op.
- stall_o = (state==SHIFT) | queue_full. It is registered-state based with no combinational path from stall_i. A full queue blocks accept even in a cycle where a pop occurs.
- Queue: FIFO order. Simultaneous push and pop on a non-full, non-empty queue keeps the count. Pointers wrap modulo OUT_DEPTH. result_o is don't-care when v_o=0.
- Reset (rst=0, asynchronous):
  - v_o=0, result_o=0, flags_o=0, stall_o=0.
  - FSM=IDLE, queue empty, pointers 0.
  - A reset mid-shift aborts the shift with no queue write.
  - Normal operation resumes on the first edge after rst deasserts.

Decomposition:
- Package ex_pkg holds:
  - opcode low-bit encodings (ADD/SUB, AND/OR/XOR/NOT, SLL/SRL/SRA/ROL)
  - flag bit indices FLAG_Z=5, FLAG_P=4, FLAG_N=3, FLAG_C=2, FLAG_V=1
  - FSM state type {IDLE, SHIFT}
- Sub-module ex_out_fifo (parameters WIDTH and OUT_DEPTH; push, pop, full, empty, head data).
- The ALU datapath and FSM stay in ex_pipe.

Test Plan:
1. Add overflow: inte, opcode=0x00, rd=0x7FFFFFFF, rs=0x00000001 accepted at N -> v_o at N+1, result_o=0x80000000, flags_o=6'b001010.
2. Sub equal: inte, opcode=0x01, rd=5, rs=5 -> result_o=0, flags_o=6'b100100 (Z=1, C=1).
3. SRA: SERIAL_SHIFT=1, shift, opcode=0x02, rd=0x80000000, rs=4 accepted at N -> stall_o=1 in N+1..N+4, v_o at N+5, result_o=0xF8000000, flags_o=6'b001000. With SERIAL_SHIFT=0 -> same result, v_o at N+1.
4. Back-pressure: OUT_DEPTH=2, stall_i=1, three ops offered back-to-back (results 1, 2, 3) -> two accepted, stall_o=1 from the following cycle, result_o=1. Release stall_i -> pops 1, 2, then op 3 is accepted and popped, all in order.
5. Reset during SRA: rst=0 in cycle N+2 -> v_o=0, flags_o=0, stall_o=0 immediately. After release, an add 2+3 yields result_o=5 with v_o at acceptance+1.
6. Load address: ld, immf=1, rd=0x10, imm=0xFFFFFFF0 after test 1 -> result_o=0x00000000, flags_o stays 6'b001010.
